// File: rtl/pps_source.sv
// 1 PPS waveform generator with per-second period trim offered over valid/ready.
// State | meaning: IDLE output low | ARM start delay | HIGH pulse high | LOW rest of second.
`timescale 1ns/1ps
module pps_source #(
  parameter int CLK_FREQ_HZ        = 100_000_000,
  parameter int PULSE_WIDTH_CYCLES = 10_000_000,
  parameter int START_DELAY_CYCLES = 1000,
  parameter int TRIM_W             = 16
) (
  input  logic              CLK_100MHZ,
  input  logic              nRST,
  input  logic              ENABLE,
  input  logic              TRIM_VALID,
  input  logic [TRIM_W-1:0] TRIM_VALUE,
  output logic              TRIM_READY,
  output logic              GPS_PPS,
  output logic              PPS_STROBE,
  output logic [31:0]       SECOND_COUNT
);

  localparam int CW = $clog2(CLK_FREQ_HZ + 2**(TRIM_W-1));
  localparam logic signed [CW:0]   CLK_S      = (CW+1)'(CLK_FREQ_HZ);
  localparam logic signed [CW:0]   ONE_S      = (CW+1)'(1);
  localparam logic        [CW-1:0] PW_LAST    = CW'(PULSE_WIDTH_CYCLES - 1);
  localparam logic        [CW-1:0] DELAY_LAST = CW'(START_DELAY_CYCLES - 1);

  if (CLK_FREQ_HZ - 2**(TRIM_W-1) <= PULSE_WIDTH_CYCLES) begin : g_bad_period
    $error("pps_source: worst-case trimmed period does not exceed the pulse width");
  end
  if (START_DELAY_CYCLES < 1 || START_DELAY_CYCLES > 2**CW) begin : g_bad_delay
    $error("pps_source: START_DELAY_CYCLES out of range for the counter");
  end

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      pps_q, pps_d;
  logic                      strobe_q, strobe_d;
  logic [31:0]               sec_cnt_q, sec_cnt_d;
  logic signed [TRIM_W-1:0]  pend_q, pend_d;
  logic signed [TRIM_W-1:0]  act_q, act_d;
  logic                      ready_q, ready_d;

  logic                      rise;
  logic signed [CW:0]        trim_ext;
  logic signed [CW:0]        period_last;

  always_comb begin
    trim_ext    = (CW+1)'(act_q);
    period_last = CLK_S + trim_ext - ONE_S;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    pps_d     = pps_q;
    strobe_d  = 1'b0;
    sec_cnt_d = sec_cnt_q;
    pend_d    = pend_q;
    act_d     = act_q;
    ready_d   = ready_q;
    rise      = 1'b0;

    if (!ENABLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      pps_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
          pps_d   = 1'b0;
        end
        ARM:  rise = (cnt_q == DELAY_LAST);
        HIGH: begin
          if (cnt_q == PW_LAST) begin
            state_d = LOW;
            pps_d   = 1'b0;
          end
        end
        LOW:  rise = ($signed({1'b0, cnt_q}) == period_last);
        default: state_d = IDLE;
      endcase
    end

    // The second starting at this edge uses whatever trim was pending before it.
    if (rise) begin
      state_d   = HIGH;
      cnt_d     = '0;
      pps_d     = 1'b1;
      strobe_d  = 1'b1;
      sec_cnt_d = sec_cnt_q + 32'd1;
      act_d     = ready_q ? '0 : pend_q;
      pend_d    = '0;
      ready_d   = 1'b1;
    end

    if (TRIM_VALID && ready_q) begin
      pend_d  = TRIM_VALUE;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_100MHZ or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pps_q     <= 1'b0;
      strobe_q  <= 1'b0;
      sec_cnt_q <= '0;
      pend_q    <= '0;
      act_q     <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pps_q     <= pps_d;
      strobe_q  <= strobe_d;
      sec_cnt_q <= sec_cnt_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      ready_q   <= ready_d;
    end
  end

  assign GPS_PPS      = pps_q;
  assign PPS_STROBE   = strobe_q;
  assign SECOND_COUNT = sec_cnt_q;
  assign TRIM_READY   = ready_q;

endmodule

// File: tb/tb_pps_source.sv
// Directed bench for pps_source: expected PPS rises are queued by the stimulus and
// checked by a strobe monitor; level checks are made inline.
`timescale 1ns/1ps
module tb_pps_source;

  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          enable;
  logic          trim_valid;
  logic [TW-1:0] trim_value;
  logic          trim_ready;
  logic          gps_pps;
  logic          pps_strobe;
  logic [31:0]   second_count;

  pps_source #(
    .CLK_FREQ_HZ(1000), .PULSE_WIDTH_CYCLES(100), .START_DELAY_CYCLES(10), .TRIM_W(TW)
  ) dut (
    .CLK_100MHZ(clk), .nRST(nrst), .ENABLE(enable), .TRIM_VALID(trim_valid),
    .TRIM_VALUE(trim_value), .TRIM_READY(trim_ready), .GPS_PPS(gps_pps),
    .PPS_STROBE(pps_strobe), .SECOND_COUNT(second_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_n;
    logic [31:0] count;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned edge_n = 0;
  int          n_vec  = 0;
  int          n_err  = 0;

  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, edge_n);
    end
  endtask

  // Monitor: every strobe must match the next queued rise.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (pps_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rise_edge", edge_n, e.edge_n);
        chk("rise_count", second_count, e.count);
        chk("rise_pps", {31'd0, gps_pps}, 32'd1);
      end
    end
  end

  task automatic push_rise(input int unsigned e, input logic [31:0] c);
    exp_t x;
    x.edge_n = e;
    x.count  = c;
    exp_q.push_back(x);
  endtask

  task automatic wait_edge(input int unsigned k);
    while (edge_n < k) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst       = 1'b0;
    enable     = 1'b0;
    trim_valid = 1'b0;
    trim_value = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic start_enable(output int unsigned base);
    @(negedge clk);
    enable = 1'b1;
    base   = edge_n + 1;
  endtask

  task automatic offer_trim(input int unsigned at_edge, input logic [TW-1:0] v);
    wait_edge(at_edge - 1);
    trim_valid = 1'b1;
    trim_value = v;
    wait_edge(at_edge);
    trim_valid = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int unsigned b, b2;
    nrst = 1'b1; enable = 1'b0; trim_valid = 1'b0; trim_value = '0;

    // Reset state and free-running seconds
    do_reset();
    chk("rst_pps", {31'd0, gps_pps}, 32'd0);
    chk("rst_strobe", {31'd0, pps_strobe}, 32'd0);
    chk("rst_count", second_count, 32'd0);
    chk("rst_ready", {31'd0, trim_ready}, 32'd1);
    start_enable(b);
    push_rise(b + 10, 1); push_rise(b + 1010, 2); push_rise(b + 2010, 3);
    wait_edge(b + 9);
    chk("pre_rise_low", {31'd0, gps_pps}, 32'd0);
    wait_edge(b + 11);
    chk("strobe_one_cycle", {31'd0, pps_strobe}, 32'd0);
    wait_edge(b + 109);
    chk("pulse_last_high", {31'd0, gps_pps}, 32'd1);
    wait_edge(b + 110);
    chk("pulse_fall", {31'd0, gps_pps}, 32'd0);
    wait_drain(2100);

    // +25 trim offered mid-second 1
    do_reset();
    start_enable(b);
    push_rise(b + 10, 1); push_rise(b + 1010, 2); push_rise(b + 2035, 3); push_rise(b + 3035, 4);
    offer_trim(b + 500, 8'd25);
    chk("trim_ready_drop", {31'd0, trim_ready}, 32'd0);
    wait_edge(b + 1009);
    chk("trim_ready_held", {31'd0, trim_ready}, 32'd0);
    wait_edge(b + 1010);
    chk("trim_ready_back", {31'd0, trim_ready}, 32'd1);
    wait_drain(3100);

    // -30 trim transferred on the rise edge itself: applies one second later, then reverts
    do_reset();
    start_enable(b);
    push_rise(b + 10, 1); push_rise(b + 1010, 2); push_rise(b + 2010, 3);
    push_rise(b + 2980, 4); push_rise(b + 3980, 5);
    offer_trim(b + 1010, 8'(-30));
    chk("edge_trim_ready", {31'd0, trim_ready}, 32'd0);
    wait_edge(b + 2010);
    chk("edge_trim_ready_back", {31'd0, trim_ready}, 32'd1);
    wait_drain(4100);

    // Disable mid-pulse, then re-enable
    do_reset();
    start_enable(b);
    push_rise(b + 10, 1);
    wait_edge(b + 60);
    chk("mid_pulse_high", {31'd0, gps_pps}, 32'd1);
    enable = 1'b0;
    wait_edge(b + 61);
    chk("truncated_pulse", {31'd0, gps_pps}, 32'd0);
    wait_edge(b + 70);
    chk("idle_low", {31'd0, gps_pps}, 32'd0);
    start_enable(b2);
    push_rise(b2 + 10, 2);
    wait_edge(b2 + 9);
    chk("rearm_low", {31'd0, gps_pps}, 32'd0);
    wait_drain(100);

    // Reset during HIGH with a trim pending
    offer_trim(b2 + 21, 8'd5);
    chk("pend_before_rst", {31'd0, trim_ready}, 32'd0);
    wait_edge(b2 + 30);
    chk("high_before_rst", {31'd0, gps_pps}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("async_rst_pps", {31'd0, gps_pps}, 32'd0);
    chk("async_rst_count", second_count, 32'd0);
    chk("async_rst_ready", {31'd0, trim_ready}, 32'd1);
    @(negedge clk);
    enable = 1'b0;
    nrst   = 1'b1;

    // SECOND_COUNT wrap
    do_reset();
    start_enable(b);
    push_rise(b + 10, 1);
    wait_drain(100);
    wait_edge(b + 500);
    dut.sec_cnt_q = 32'hFFFF_FFFF;
    push_rise(b + 1010, 32'd0);
    wait_drain(700);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
